// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and WIDTH bounds.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/fa_nand_cell.sv
// One-bit full adder built from nine 2-input NAND gates; the single arithmetic cell
// reused every cycle by serial_adder.
module fa_nand_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    logic n_ab, n_a, n_b, x_ab, n_xc, n_x, n_c;

    nand g0 (n_ab, a, b);
    nand g1 (n_a, a, n_ab);
    nand g2 (n_b, b, n_ab);
    nand g3 (x_ab, n_a, n_b);
    nand g4 (n_xc, x_ab, c);
    nand g5 (n_x, x_ab, n_xc);
    nand g6 (n_c, c, n_xc);
    nand g7 (sum, n_x, n_c);
    // carry = a&b | (a^b)&c, both product terms already exist as NAND outputs
    nand g8 (carry, n_ab, n_xc);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: LSB-first, one bit per clock through a single full-adder
// cell, with start/busy/done handshake and signed-overflow reporting.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH must be within 1..64");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opb_q, acc_q, sum_q;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q, cout_q, ovf_q;
    logic             fa_sum, fa_carry;
    logic             load, step, last;

    fa_nand_cell u_fa (
        .a     (opa_q[0]),
        .b     (opb_q[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign load  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign step  = (state_q == ST_RUN);
    assign last  = step && (cnt_q == LAST_CNT);
    assign acc_d = (acc_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is a + ~b + ~cin, so the same cell and overflow rule serve both modes
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            opa_q   <= a;
            opb_q   <= b ^ {WIDTH{sub}};
            carry_q <= cin ^ sub;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (step) begin
            opa_q   <= opa_q >> 1;
            opb_q   <= opb_q >> 1;
            carry_q <= fa_carry;
            acc_q   <= acc_d;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last) begin
                sum_q  <= acc_d;
                cout_q <= fa_carry;
                ovf_q  <= carry_q ^ fa_carry;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed WIDTH=8 vectors plus exhaustive WIDTH=2/1 sweeps.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       start8, cin8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, sub2, busy2, done2, cout2, ovf2;
    logic [1:0] a2, b2, sum2;
    logic       start1, cin1, sub1, busy1, done1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;

    logic [9:0] q8[$];
    logic [3:0] q2[$];
    logic [2:0] q1[$];
    logic [9:0] e8;
    logic [3:0] e2;
    logic [2:0] e1;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );
    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );
    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: (a +/- b +/- cin) mod 2^w, no-borrow cout for sub, signed range test for ovf
    task automatic model(input int w, input int av, input int bv, input int ci, input int su,
                         output int s, output int co, output int ov);
        int m, r, sa, sb, sr;
        m  = 1 << w;
        r  = su ? (av - bv - ci) : (av + bv + ci);
        s  = ((r % m) + m) % m;
        co = su ? int'(av >= bv + ci) : int'(r >= m);
        sa = (av >= m / 2) ? av - m : av;
        sb = (bv >= m / 2) ? bv - m : bv;
        sr = su ? (sa - sb - ci) : (sa + sb + ci);
        ov = int'(sr < -(m / 2) || sr > (m / 2) - 1);
    endtask

    always @(negedge clk) begin
        if (done8) begin
            check("w8_pending", 64'(q8.size() > 0), 64'(1));
            if (q8.size() > 0) begin
                e8 = q8.pop_front();
                check("w8_sum", 64'(sum8), 64'(e8[9:2]));
                check("w8_cout", 64'(cout8), 64'(e8[1]));
                check("w8_ovf", 64'(ovf8), 64'(e8[0]));
                check("w8_busy_at_done", 64'(busy8), 64'(0));
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            check("w2_pending", 64'(q2.size() > 0), 64'(1));
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                check("w2_sum", 64'(sum2), 64'(e2[3:2]));
                check("w2_cout", 64'(cout2), 64'(e2[1]));
                check("w2_ovf", 64'(ovf2), 64'(e2[0]));
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            check("w1_pending", 64'(q1.size() > 0), 64'(1));
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                check("w1_sum", 64'(sum1), 64'(e1[2]));
                check("w1_cout", 64'(cout1), 64'(e1[1]));
                check("w1_ovf", 64'(ovf1), 64'(e1[0]));
            end
        end
    end

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic su,
                       input logic [7:0] es, input logic ec, input logic eo, input int disturb);
        int n, nbusy;
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = ci; sub8 = su; start8 = 1'b1;
        q8.push_back({es, ec, eo});
        @(negedge clk);
        start8 = 1'b0;
        n      = 1;
        nbusy  = 0;
        check("w8_clear_on_start", 64'(sum8), 64'(0));
        while (!done8 && n < 40) begin
            if (busy8) nbusy++;
            if (disturb != 0 && n == disturb) begin
                start8 = 1'b1; a8 = ~av; b8 = ~bv; cin8 = ~ci; sub8 = ~su;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check("w8_latency", 64'(n), 64'(9));
        check("w8_busy_cycles", 64'(nbusy), 64'(8));
        @(negedge clk);
        check("w8_idle_after_done", 64'({busy8, done8}), 64'(0));
        repeat (2) @(negedge clk);
        check("w8_hold", 64'({sum8, cout8, ovf8}), 64'({es, ec, eo}));
    endtask

    initial begin
        int n, ndone, es, ec, eo;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_w8", 64'({busy8, done8, sum8, cout8, ovf8}), 64'(0));
        check("rst_w2", 64'({busy2, done2, sum2, cout2, ovf2}), 64'(0));
        check("rst_w1", 64'({busy1, done1, sum1, cout1, ovf1}), 64'(0));
        rst = 1'b0;

        op8(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 0);
        op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        op8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
        op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
        op8(8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 0);
        op8(8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0, 0);
        op8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 3);

        // Back-to-back: start held high through DONE
        @(negedge clk);
        a8 = 8'h21; b8 = 8'h11; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        q8.push_back({8'h32, 1'b0, 1'b0});
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_latency", 64'(n), 64'(9));
        a8 = 8'h40; b8 = 8'h05; sub8 = 1'b1;
        q8.push_back({8'h3B, 1'b1, 1'b0});
        @(negedge clk);
        check("b2b_no_idle", 64'(busy8), 64'(1));
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_latency", 64'(n), 64'(9));
        repeat (2) @(negedge clk);

        // Reset in RUN cycle 3 aborts the operation
        a8 = 8'h55; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
        q8.push_back({8'h77, 1'b0, 1'b0});
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        void'(q8.pop_back());
        @(negedge clk);
        check("rst_mid_run", 64'({busy8, done8, sum8, cout8, ovf8}), 64'(0));
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        check("rst_no_done", 64'(ndone), 64'(0));
        op8(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 0);

        for (int av = 0; av < 4; av++)
            for (int bv = 0; bv < 4; bv++)
                for (int ci = 0; ci < 2; ci++)
                    for (int su = 0; su < 2; su++) begin
                        model(2, av, bv, ci, su, es, ec, eo);
                        @(negedge clk);
                        a2 = 2'(av); b2 = 2'(bv); cin2 = ci[0]; sub2 = su[0]; start2 = 1'b1;
                        q2.push_back({es[1:0], ec[0], eo[0]});
                        @(negedge clk);
                        start2 = 1'b0;
                        n = 1;
                        while (!done2 && n < 20) begin
                            @(negedge clk);
                            n++;
                        end
                        check("w2_latency", 64'(n), 64'(3));
                    end

        for (int av = 0; av < 2; av++)
            for (int bv = 0; bv < 2; bv++)
                for (int ci = 0; ci < 2; ci++)
                    for (int su = 0; su < 2; su++) begin
                        model(1, av, bv, ci, su, es, ec, eo);
                        @(negedge clk);
                        a1 = 1'(av); b1 = 1'(bv); cin1 = ci[0]; sub1 = su[0]; start1 = 1'b1;
                        q1.push_back({es[0], ec[0], eo[0]});
                        @(negedge clk);
                        start1 = 1'b0;
                        n = 1;
                        while (!done1 && n < 20) begin
                            @(negedge clk);
                            n++;
                        end
                        check("w1_latency", 64'(n), 64'(2));
                    end

        repeat (3) @(negedge clk);
        check("q8_drained", 64'(q8.size()), 64'(0));
        check("q2_drained", 64'(q2.size()), 64'(0));
        check("q1_drained", 64'(q1.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor that adds two WIDTH-bit operands one bit per clock, LSB first, through a single NAND-built full-adder cell and a carry flip-flop. It is the sequential, multi-bit successor to the team's one-bit combinational full adder: same arithmetic cell, now reused across WIDTH cycles under a start/busy/done handshake. It adds a subtract mode and signed-overflow reporting. It sits in the datapath wherever area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- CNT_W (localparam), $clog2(WIDTH+1), bit-counter width.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; sampled at the accepted start edge.
- b  in  WIDTH  operand B; sampled at the accepted start edge.
- cin  in  1  carry-in; sampled at the accepted start edge.
- sub  in  1  0 = a+b+cin, 1 = a-b-cin; sampled at the accepted start edge.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result; held until the next accepted start.
- cout  out  1  final carry out. With sub=1, 1 means no borrow.
- ovf  out  1  two's-complement overflow.

## Operation
- FSM states are IDLE, RUN and DONE. Reset forces IDLE.
- IDLE, start=1: load the operand shift registers.
  - opA <= a.
  - opB <= b ^ {WIDTH{sub}}.
  - carry <= cin ^ sub.
  - Clear cnt and the sum register. Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - Compute bit = fa(opA[0], opB[0], carry).
  - Shift bit into the MSB of the sum register, which shifts right.
  - Shift opA and opB right. carry <= the cell's carry. cnt++.
  - When cnt reaches WIDTH-1 on this edge, go to DONE.
- Latch the carry into the MSB position on the last RUN edge. Then ovf = carry_into_msb ^ final_carry and cout = final_carry.
- DONE: done=1 for exactly one cycle.
  - start=1 loads a new operation and goes to RUN (back-to-back).
  - Otherwise go to IDLE.
- start in RUN is ignored. Changes on a, b, cin or sub during RUN have no effect.
- WIDTH=1 is legal: RUN lasts one edge, and ovf = cin-to-msb ^ cout.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0. Internal registers and cnt are 0 and state is IDLE.
- rst=1 mid-operation aborts on that edge: all outputs return to reset values and no done pulse occurs. rst has priority over start.
- Start accepted at edge k:
  - busy=1 during the WIDTH cycles following edges k..k+WIDTH-1.
  - done=1 during the cycle after edge k+WIDTH.
  - sum, cout and ovf are valid from edge k+WIDTH.
- Latency is WIDTH clocks from start to done. Throughput is one operation per WIDTH+1 clocks.
- busy and done are never high together.
- sum, cout and ovf change only on the final RUN edge or on reset. They hold through DONE and IDLE. They clear on a new accepted start.

## Structure
- Shared package serial_adder_pkg:
  - State encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10; 2'b11 recovers to IDLE.
  - WIDTH legality bounds.
- Sub-module fa_nand_cell: one-bit full adder (a, b, c -> sum, carry) built only from 2-input NAND primitives, instantiated once. The FSM, counter and shift registers stay in the top.

## Test plan
- Add (WIDTH=8): a=0x0F, b=0x01, cin=0, sub=0 -> sum=0x10, cout=0, ovf=0. done pulses exactly 8 clocks after start, and busy is high for 8 cycles.
- Add overflow/carry: 0x7F+0x01 -> sum=0x80, cout=0, ovf=1. 0xFF+0x01 -> sum=0x00, cout=1, ovf=0.
- Subtract: 0x05-0x07 -> sum=0xFE, cout=0, ovf=0. 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
- Handshake:
  - start pulsed at RUN cycle 3 is ignored, and flipping a/b mid-run does not alter the result.
  - start held high through DONE launches the next operation with no IDLE cycle; the second result is correct.
- Reset: rst=1 at RUN cycle 3 -> busy, done, sum, cout and ovf are 0 after that edge, with no done pulse. A following 0x03+0x04 gives sum=0x07.
- Exhaustive: WIDTH=2 and WIDTH=1 over all a, b, cin, sub combinations. Compare against the model (a ± b ± cin) mod 2^WIDTH, plus the cout and ovf formulas.
